guess_display: RTL and testbench
================================

// Module: guess_display
// PURPOSE
//   Display stage directly downstream of the guess game core. Takes the four
//   3-bit digit values (0-7) and the 2-bit selected-digit index, and drives a
//   4-digit common-anode 7-segment display by time multiplexing.
//   The selected digit blinks so the player can see which position the
//   left/right buttons move and the up/down buttons change.
// PARAMETERS
//   SCAN_DIV   100000    clk cycles per digit slot (>=2); 1 kHz/digit @100 MHz
//   BLINK_DIV  25000000  clk cycles per blink half-period (>=2); 2 Hz toggle
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   rst_n      in   1  asynchronous reset, active low
//   enable     in   1  1 = display active; 0 = display blanked
//   digit0     in   3  leftmost digit value (driven by guess led_zero)
//   digit1     in   3  second digit value (led_one)
//   digit2     in   3  third digit value (led_two)
//   digit3     in   3  rightmost digit value (led_three)
//   sel        in   2  index of the selected digit (blink_led), 0 = leftmost
//   blink_en   in   1  1 = selected digit blinks; 0 = all digits steady
//   seg        out  7  segments {g,f,e,d,c,b,a}, active low
//   an         out  4  digit anodes, active low; an[3] = digit0 ... an[0] = digit3
//   dp         out  1  decimal point, active low, held 1 (off)
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous, any cycle):
//   - Outputs: an=4'hF, seg=7'h7F, dp=1.
//   - State: scan counter=0, digit index=0, blink counter=0, blink phase=0 (on).
// - Scan counter
//   - Counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, index advances 0->1->2->3->0.
//   - Runs regardless of enable.
// - Blink counter
//   - Counts 0..BLINK_DIV-1; phase toggles on wrap.
//   - Phase 0 = on, 1 = off.
//   - Runs regardless of blink_en.
// - Output timing
//   - All outputs registered. seg/an reflect inputs and index sampled on the
//     same edge, so latency from any input change to the outputs is 1 cycle.
// - Anode per cycle
//   - Guard cycle: scan count == SCAN_DIV-1 -> an=4'hF (anti-ghosting).
//   - Else if enable=0 -> an=4'hF.
//   - Else if blink_en=1 and phase=1 and index==sel -> an=4'hF.
//   - Else an = one-hot-low for the index: 0->0111, 1->1011, 2->1101, 3->1110.
// - Segments
//   - seg = encode(digit[index]) whenever enable=1, including blanked/guard
//     cycles; seg=7'h7F when enable=0.
//   - Encoding: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 (hex).
// - Input changes
//   - sel or digit changes mid-slot take effect on the next edge; no
//     restart of counters.
// - Re-enable: enable 0->1 resumes at the current index/count (no resync).
// - Reset release: first edge with enable=1 and count 0 gives
//   an=0111, seg=encode(digit0).
// TESTING (bench params: SCAN_DIV=4, BLINK_DIV=16)
// 1. rst_n low mid-slot -> an=F, seg=7F, dp=1 without a clk edge; release ->
//    first edge an=0111.
// 2. Scan: digits 1,2,3,4, blink_en=0, enable=1 -> an 0111 x3, F x1, 1011 x3,
//    F, 1101 x3, F, 1110 x3, F, then 0111; seg 79/24/30/19 in the lit cycles.
// 3. Blink: sel=2, blink_en=1 -> phase 0 (16 cycles) shows 1101; phase 1
//    (next 16) an never 1101; digits 0, 1, 3 unaffected; alternates thereafter.
// 4. enable=0 for 10 cycles -> an=F, seg=7F from next edge; re-enable ->
//    lit digit matches counter position (index advanced by elapsed slots).
// 5. digit0 3->7 while index 0 lit -> seg 30 then 78 one cycle later;
//    an unchanged.
// 6. sel changed 2->0 during blink-off phase -> digit2 relit and digit0 dark
//    from the next edge.

Source files
------------

// File: rtl/guess_display.sv
// Time-multiplexed 4-digit 7-segment driver for the guess game core.
// The selected digit blinks; every output is registered.
module guess_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] digit0,
  input  logic [2:0] digit1,
  input  logic [2:0] digit2,
  input  logic [2:0] digit3,
  input  logic [1:0] sel,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic [2:0] w_digit;
  logic [6:0] w_enc;
  logic [3:0] w_onehot;
  logic       w_guard;
  logic       w_blank;
  logic [3:0] w_an;
  logic [6:0] w_seg;

  always_comb begin
    w_digit = digit0;
    unique case (r_idx)
      2'd0: w_digit = digit0;
      2'd1: w_digit = digit1;
      2'd2: w_digit = digit2;
      2'd3: w_digit = digit3;
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, low = lit.
  always_comb begin
    w_enc = 7'h7F;
    unique case (w_digit)
      3'd0: w_enc = 7'h40;
      3'd1: w_enc = 7'h79;
      3'd2: w_enc = 7'h24;
      3'd3: w_enc = 7'h30;
      3'd4: w_enc = 7'h19;
      3'd5: w_enc = 7'h12;
      3'd6: w_enc = 7'h02;
      3'd7: w_enc = 7'h78;
    endcase
  end

  always_comb begin
    w_onehot = 4'b0111;
    unique case (r_idx)
      2'd0: w_onehot = 4'b0111;
      2'd1: w_onehot = 4'b1011;
      2'd2: w_onehot = 4'b1101;
      2'd3: w_onehot = 4'b1110;
    endcase
  end

  // Last cycle of each slot is dark so the next digit never ghosts.
  assign w_guard = (r_scan_cnt == SCAN_LAST);
  assign w_blank = blink_en & r_phase & (r_idx == sel);

  always_comb begin
    w_an  = w_onehot;
    w_seg = w_enc;
    if (w_guard || !enable || w_blank) begin
      w_an = 4'hF;
    end
    if (!enable) begin
      w_seg = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (w_guard) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_guess_display.sv
// Directed bench for guess_display with SCAN_DIV=4, BLINK_DIV=16.
// Edge k after reset release uses slot (k-1)/4 and blink phase (k-1)/16.
module tb_guess_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] digit0 = 3'd0;
  logic [2:0] digit1 = 3'd0;
  logic [2:0] digit2 = 3'd0;
  logic [2:0] digit3 = 3'd0;
  logic [1:0] sel = 2'd0;
  logic       blink_en = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  localparam logic [3:0] T_AN [17] = '{
    4'h7, 4'h7, 4'h7, 4'hF,
    4'hB, 4'hB, 4'hB, 4'hF,
    4'hD, 4'hD, 4'hD, 4'hF,
    4'hE, 4'hE, 4'hE, 4'hF,
    4'h7
  };
  localparam logic [6:0] T2_SEG [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [6:0] T3_SEG [4] = '{7'h12, 7'h02, 7'h78, 7'h40};
  localparam int         T6_K   [9] = '{25, 26, 27, 28, 33, 49, 50, 51, 52};
  localparam logic [3:0] T6_AN  [9] = '{
    4'hF, 4'hD, 4'hD, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF
  };

  guess_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .digit3(digit3),
    .sel(sel), .blink_en(blink_en),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic set_digits(input logic [2:0] a, b, c, d);
    digit0 = a; digit1 = b; digit2 = c; digit3 = d;
  endtask

  task automatic test_reset();
    do_reset();
    set_digits(3'd1, 3'd2, 3'd3, 3'd4);
    enable = 1'b1; blink_en = 1'b0; sel = 2'd0;
    tick(); tick();
    checks++;
    if (an !== 4'h7) begin
      failures++;
      $display("FAIL pre_reset_an got=%h exp=7", an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got an=%h seg=%h dp=%b exp F/7F/1",
               an, seg, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    tick();
    checks++;
    if (an !== 4'h7 || seg !== 7'h79) begin
      failures++;
      $display("FAIL release_first got an=%h seg=%h exp 7/79", an, seg);
    end
    tick(); tick(); tick();
    checks++;
    if (an !== 4'hF) begin
      failures++;
      $display("FAIL release_guard got an=%h exp F", an);
    end
  endtask

  task automatic test_scan();
    do_reset();
    set_digits(3'd1, 3'd2, 3'd3, 3'd4);
    enable = 1'b1; blink_en = 1'b0; sel = 2'd2;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (an !== T_AN[k-1] || seg !== T2_SEG[((k-1)/4)%4]) begin
        failures++;
        $display("FAIL scan edge=%0d got an=%h seg=%h exp %h/%h",
                 k, an, seg, T_AN[k-1], T2_SEG[((k-1)/4)%4]);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp_an;
    do_reset();
    set_digits(3'd5, 3'd6, 3'd7, 3'd0);
    enable = 1'b1; blink_en = 1'b1; sel = 2'd2;
    for (int k = 1; k <= 48; k++) begin
      tick();
      exp_an = T_AN[(k-1)%16];
      if (((k-1)/16)%2 == 1 && ((k-1)%16)/4 == 2) exp_an = 4'hF;
      checks++;
      if (an !== exp_an || seg !== T3_SEG[((k-1)/4)%4]) begin
        failures++;
        $display("FAIL blink edge=%0d got an=%h seg=%h exp %h/%h",
                 k, an, seg, exp_an, T3_SEG[((k-1)/4)%4]);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    set_digits(3'd1, 3'd2, 3'd3, 3'd4);
    enable = 1'b1; blink_en = 1'b0; sel = 2'd0;
    tick(); tick();
    enable = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      tick();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F) begin
        failures++;
        $display("FAIL disabled edge=%0d got an=%h seg=%h exp F/7F",
                 k, an, seg);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (an !== 4'hE || seg !== 7'h19) begin
      failures++;
      $display("FAIL reenable got an=%h seg=%h exp E/19", an, seg);
    end
    tick();
    checks++;
    if (an !== 4'hE || seg !== 7'h19) begin
      failures++;
      $display("FAIL reenable2 got an=%h seg=%h exp E/19", an, seg);
    end
  endtask

  task automatic test_digit_change();
    do_reset();
    set_digits(3'd3, 3'd2, 3'd1, 3'd0);
    enable = 1'b1; blink_en = 1'b0; sel = 2'd0;
    tick();
    checks++;
    if (an !== 4'h7 || seg !== 7'h30) begin
      failures++;
      $display("FAIL digit_before got an=%h seg=%h exp 7/30", an, seg);
    end
    digit0 = 3'd7;
    #1;
    checks++;
    if (seg !== 7'h30) begin
      failures++;
      $display("FAIL digit_registered got seg=%h exp 30", seg);
    end
    tick();
    checks++;
    if (an !== 4'h7 || seg !== 7'h78) begin
      failures++;
      $display("FAIL digit_after got an=%h seg=%h exp 7/78", an, seg);
    end
  endtask

  task automatic test_sel_change();
    int j;
    do_reset();
    set_digits(3'd1, 3'd2, 3'd3, 3'd4);
    enable = 1'b1; blink_en = 1'b1; sel = 2'd2;
    j = 0;
    while (edge_n < 52) begin
      tick();
      if (edge_n == 25) sel = 2'd0;
      if (j < 9 && edge_n == T6_K[j]) begin
        checks++;
        if (an !== T6_AN[j]) begin
          failures++;
          $display("FAIL sel_change edge=%0d got an=%h exp %h",
                   edge_n, an, T6_AN[j]);
        end
        j++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_enable();
    test_digit_change();
    test_sel_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
